// File: rtl/halftone_pkg.sv
`default_nettype none
// ============================================================================
// Module      : halftone_pkg
// Description : Shared constants and helpers for the streaming halftoner.
// Revision    : 1.0 - initial release
// ============================================================================
package halftone_pkg;

    localparam int C_DEF_PIX_W  = 8;
    localparam int C_DEF_THRESH = 128;
    localparam int C_DEF_W_L    = 2;
    localparam int C_DEF_W_UL   = 8;
    localparam int C_DEF_W_U    = 4;
    localparam int C_DEF_W_UR   = 2;

    // Weights are normalised by a 4-bit arithmetic shift, so they must sum to 16.
    localparam int C_WEIGHT_SUM   = 16;
    localparam int C_WEIGHT_SHIFT = 4;

    function automatic int err_w(input int pix_w);
        return pix_w + 2;
    endfunction

    function automatic int sat_err(input int value, input int width);
        int hi;
        int lo;
        hi = (1 << (width - 1)) - 1;
        lo = -(1 << (width - 1));
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/halftone_stream_converter_if.sv
`default_nettype none
// ============================================================================
// Module      : halftone_stream_converter_if
// Description : Pixel-in / halftone-bit-out stream bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface halftone_stream_converter_if #(
    parameter int PIX_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_pixel;
    logic             in_sof;
    logic             diffuse_en;
    logic             out_valid;
    logic             out_ready;
    logic             out_bit;
    logic             out_eol;
    logic             out_eof;

    modport master (
        output in_valid, in_pixel, in_sof, diffuse_en, out_ready,
        input  in_ready, out_valid, out_bit, out_eol, out_eof
    );

    modport slave (
        input  in_valid, in_pixel, in_sof, diffuse_en, out_ready,
        output in_ready, out_valid, out_bit, out_eol, out_eof
    );
endinterface
`default_nettype wire

// File: rtl/halftone_pixel_core.sv
`default_nettype none
// ============================================================================
// Module      : halftone_pixel_core
// Description : Combinational error-diffusion decision for a single pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module halftone_pixel_core
    import halftone_pkg::*;
#(
    parameter int PIX_W  = C_DEF_PIX_W,
    parameter int THRESH = C_DEF_THRESH,
    parameter int W_L    = C_DEF_W_L,
    parameter int W_UL   = C_DEF_W_UL,
    parameter int W_U    = C_DEF_W_U,
    parameter int W_UR   = C_DEF_W_UR,
    localparam int ERR_W = err_w(PIX_W)
) (
    input  wire logic [PIX_W-1:0]        i_pixel,
    input  wire logic signed [ERR_W-1:0] i_err_l,
    input  wire logic signed [ERR_W-1:0] i_err_ul,
    input  wire logic signed [ERR_W-1:0] i_err_u,
    input  wire logic signed [ERR_W-1:0] i_err_ur,
    input  wire logic                    i_diffuse_en,
    output logic                         o_bit,
    output logic signed [ERR_W-1:0]      o_err
);

    localparam int SUM_W = ERR_W + 6;
    localparam int CPV_W = PIX_W + 3;
    localparam logic signed [CPV_W:0] C_WHITE = (CPV_W+1)'((1 << PIX_W) - 1);

    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_eav;
    logic signed [CPV_W-1:0] w_cpv;
    logic signed [CPV_W:0]   w_err_raw;
    int                      w_err_sat;

    always_comb begin
        w_sum = $signed(SUM_W'(W_L))  * $signed(SUM_W'(i_err_l))
              + $signed(SUM_W'(W_UL)) * $signed(SUM_W'(i_err_ul))
              + $signed(SUM_W'(W_U))  * $signed(SUM_W'(i_err_u))
              + $signed(SUM_W'(W_UR)) * $signed(SUM_W'(i_err_ur));
        w_eav = i_diffuse_en ? (w_sum >>> C_WEIGHT_SHIFT) : '0;
        w_cpv = $signed({3'b000, i_pixel}) + $signed(CPV_W'(w_eav));
        o_bit = (w_cpv >= $signed(CPV_W'(THRESH)));
        w_err_raw = $signed((CPV_W+1)'(w_cpv)) - (o_bit ? C_WHITE : '0);
        w_err_sat = sat_err(int'(w_err_raw), ERR_W);
        o_err     = i_diffuse_en ? ERR_W'(w_err_sat) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/halftone_stream_converter.sv
`default_nettype none
// ============================================================================
// Module      : halftone_stream_converter
// Description : Streaming raster-order error-diffusion halftoner with a
//               one-row error line buffer and a single output register.
// Revision    : 1.0 - initial release
// ============================================================================
module halftone_stream_converter
    import halftone_pkg::*;
#(
    parameter int PIX_W  = C_DEF_PIX_W,
    parameter int COLS   = 8,
    parameter int ROWS   = 6,
    parameter int THRESH = C_DEF_THRESH,
    parameter int W_L    = C_DEF_W_L,
    parameter int W_UL   = C_DEF_W_UL,
    parameter int W_U    = C_DEF_W_U,
    parameter int W_UR   = C_DEF_W_UR
) (
    input  wire logic                   clock,
    input  wire logic                   reset,
    halftone_stream_converter_if.slave  bus
);

    localparam int ERR_W = err_w(PIX_W);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [COL_W-1:0] C_LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] C_LAST_ROW = ROW_W'(ROWS - 1);

    logic [COL_W-1:0]        col_q, col_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic signed [ERR_W-1:0] left_err_q, left_err_d;
    logic signed [ERR_W-1:0] err_row_q [COLS];
    logic signed [ERR_W-1:0] err_row_d [COLS];
    logic                    out_valid_q, out_valid_d;
    logic                    out_bit_q, out_bit_d;
    logic                    out_eol_q, out_eol_d;
    logic                    out_eof_q, out_eof_d;

    logic                    w_in_ready;
    logic                    w_accept;
    logic [COL_W-1:0]        w_col;
    logic [ROW_W-1:0]        w_row;
    logic                    w_first_col;
    logic                    w_last_col;
    logic                    w_first_row;
    logic signed [ERR_W-1:0] w_e_l, w_e_ul, w_e_u, w_e_ur;
    logic                    w_bit;
    logic signed [ERR_W-1:0] w_err;

    // An accepted start-of-frame pixel is placed at (0,0) regardless of the counters.
    always_comb begin
        w_in_ready  = !out_valid_q || bus.out_ready;
        w_accept    = bus.in_valid && w_in_ready;
        w_col       = bus.in_sof ? '0 : col_q;
        w_row       = bus.in_sof ? '0 : row_q;
        w_first_col = (w_col == '0);
        w_last_col  = (w_col == C_LAST_COL);
        w_first_row = (w_row == '0);

        w_e_l  = '0;
        w_e_ul = '0;
        w_e_u  = '0;
        w_e_ur = '0;
        if (!w_first_col) begin
            w_e_l = left_err_q;
        end
        if (!w_first_row) begin
            w_e_u = err_row_q[w_col];
            if (!w_first_col) begin
                w_e_ul = err_row_q[w_col - 1'b1];
            end
            if (!w_last_col) begin
                w_e_ur = err_row_q[w_col + 1'b1];
            end
        end
    end

    halftone_pixel_core #(
        .PIX_W  (PIX_W),
        .THRESH (THRESH),
        .W_L    (W_L),
        .W_UL   (W_UL),
        .W_U    (W_U),
        .W_UR   (W_UR)
    ) u_core (
        .i_pixel      (bus.in_pixel),
        .i_err_l      (w_e_l),
        .i_err_ul     (w_e_ul),
        .i_err_u      (w_e_u),
        .i_err_ur     (w_e_ur),
        .i_diffuse_en (bus.diffuse_en),
        .o_bit        (w_bit),
        .o_err        (w_err)
    );

    // The line-buffer slot behind the current column is retired from left_err,
    // so err_row[c] and err_row[c+1] still hold the previous row when read.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        left_err_d  = left_err_q;
        err_row_d   = err_row_q;
        out_valid_d = out_valid_q;
        out_bit_d   = out_bit_q;
        out_eol_d   = out_eol_q;
        out_eof_d   = out_eof_q;

        if (w_accept) begin
            if (!w_first_col) begin
                err_row_d[w_col - 1'b1] = left_err_q;
            end
            left_err_d = w_err;
            if (w_last_col) begin
                err_row_d[C_LAST_COL] = w_err;
                col_d = '0;
                row_d = (w_row == C_LAST_ROW) ? '0 : w_row + 1'b1;
            end else begin
                col_d = w_col + 1'b1;
                row_d = w_row;
            end
            out_valid_d = 1'b1;
            out_bit_d   = w_bit;
            out_eol_d   = w_last_col;
            out_eof_d   = w_last_col && (w_row == C_LAST_ROW);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            left_err_q  <= '0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            left_err_q  <= left_err_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_eol_q   <= out_eol_d;
            out_eof_q   <= out_eof_d;
        end
    end

    // Row 0 masks every line-buffer read, so the buffer needs no reset.
    always_ff @(posedge clock) begin
        err_row_q <= err_row_d;
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bit   = out_bit_q;
    assign bus.out_eol   = out_eol_q;
    assign bus.out_eof   = out_eof_q;

endmodule
`default_nettype wire

// File: tb/tb_halftone_stream_converter.sv
`default_nettype none
// ============================================================================
// Module      : tb_halftone_stream_converter
// Description : Self-checking bench: vector table, corner sequences and a
//               randomized run against a whole-frame error-diffusion model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_halftone_stream_converter;

    localparam int PIX_W  = 8;
    localparam int COLS   = 8;
    localparam int ROWS   = 6;
    localparam int THRESH = 128;
    localparam int WL = 2, WUL = 8, WU = 4, WUR = 2;
    localparam int NPIX = COLS * ROWS;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    halftone_stream_converter_if #(.PIX_W(PIX_W)) bus ();

    halftone_stream_converter #(
        .PIX_W (PIX_W), .COLS (COLS), .ROWS (ROWS), .THRESH (THRESH),
        .W_L (WL), .W_UL (WUL), .W_U (WU), .W_UR (WUR)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct { bit b; bit eol; bit eof; } exp_t;
    typedef struct { int pix; bit de; bit b; bit eol; bit eof; } vec_t;

    exp_t exp_q[$];
    bit   obs_log[$];
    bit   ref_log[$];
    int   merr [ROWS][COLS];
    int   mrow, mcol;
    int   n_tests = 0, n_fail = 0;
    bit   obs_hs, obs_bit, obs_eol, obs_eof;
    int   out_cnt, ones_cnt, eol_cnt, eof_cnt, eof_at;
    int   pix_a [NPIX];
    vec_t tbl [16];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int floor16(input int s);
        if (s >= 0) return s / 16;
        return -((-s + 15) / 16);
    endfunction

    // Whole-frame model: every pixel's error is kept at its (row,col) position.
    task automatic model_accept(input int pix, input bit sof, input bit de);
        int el, eul, eu, eur, eav, cpv, e, lim;
        bit b;
        exp_t x;
        el = 0; eul = 0; eu = 0; eur = 0; eav = 0;
        if (sof) begin mrow = 0; mcol = 0; end
        if (de) begin
            if (mcol > 0) el = merr[mrow][mcol-1];
            if (mrow > 0) begin
                eu = merr[mrow-1][mcol];
                if (mcol > 0)        eul = merr[mrow-1][mcol-1];
                if (mcol < COLS - 1) eur = merr[mrow-1][mcol+1];
            end
            eav = floor16(WL*el + WUL*eul + WU*eu + WUR*eur);
        end
        cpv = pix + eav;
        b   = (cpv >= THRESH);
        e   = cpv - (b ? (1 << PIX_W) - 1 : 0);
        lim = 1 << (PIX_W + 1);
        if (e > lim - 1) e = lim - 1;
        if (e < -lim)    e = -lim;
        if (!de) e = 0;
        merr[mrow][mcol] = e;
        x.b   = b;
        x.eol = (mcol == COLS - 1);
        x.eof = x.eol && (mrow == ROWS - 1);
        exp_q.push_back(x);
        mcol++;
        if (mcol == COLS) begin
            mcol = 0;
            mrow = (mrow == ROWS - 1) ? 0 : mrow + 1;
        end
    endtask

    task automatic cycle(input bit v, input int pix, input bit sof, input bit de,
                         input bit ordy, output bit acc);
        exp_t x;
        bit   exp_rdy;
        @(negedge clock);
        bus.in_valid   = v;
        bus.in_pixel   = PIX_W'(pix);
        bus.in_sof     = sof;
        bus.diffuse_en = de;
        bus.out_ready  = ordy;
        #1;
        exp_rdy = (exp_q.size() == 0) || ordy;
        chk("out_valid", int'(bus.out_valid), int'(exp_q.size() != 0));
        chk("in_ready", int'(bus.in_ready), int'(exp_rdy));
        obs_hs = bus.out_valid && ordy;
        if (obs_hs) begin
            obs_bit = bus.out_bit;
            obs_eol = bus.out_eol;
            obs_eof = bus.out_eof;
            out_cnt++;
            ones_cnt += int'(obs_bit);
            eol_cnt  += int'(obs_eol);
            eof_cnt  += int'(obs_eof);
            if (obs_eof) eof_at = out_cnt;
            obs_log.push_back(obs_bit);
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                chk("out_bit", int'(obs_bit), int'(x.b));
                chk("out_eol", int'(obs_eol), int'(x.eol));
                chk("out_eof", int'(obs_eof), int'(x.eof));
            end
        end
        acc = v && exp_rdy;
        if (acc) model_accept(pix, sof, de);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sof = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
        obs_log.delete();
        mrow = 0; mcol = 0;
        out_cnt = 0; ones_cnt = 0; eol_cnt = 0; eof_cnt = 0; eof_at = 0;
        #1;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_bit", int'(bus.out_bit), 0);
        chk("rst_out_eol", int'(bus.out_eol), 0);
        chk("rst_out_eof", int'(bus.out_eof), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
    endtask

    task automatic flush();
        bit acc;
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0, 1'b1, 1'b1, acc);
    endtask

    task automatic send_frame_const(input int pix);
        bit acc;
        for (int i = 0; i < NPIX; i++) cycle(1'b1, pix, i == 0, 1'b1, 1'b1, acc);
        flush();
    endtask

    initial begin
        bit acc;
        bit snap;
        bus.in_valid = 1'b0; bus.in_pixel = '0; bus.in_sof = 1'b0;
        bus.diffuse_en = 1'b1; bus.out_ready = 1'b0;

        // Row 0 of 128s diffuses to 1,0,1,...; row 1 plain threshold on 127/128.
        for (int i = 0; i < 8; i++)
            tbl[i] = '{pix: 128, de: 1'b1, b: (i % 2 == 0), eol: (i == 7), eof: 1'b0};
        for (int i = 8; i < 16; i++)
            tbl[i] = '{pix: (i % 2 == 0) ? 127 : 128, de: 1'b0, b: (i % 2 == 1),
                       eol: (i == 15), eof: 1'b0};

        do_reset();
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) cycle(1'b1, tbl[i].pix, i == 0, tbl[i].de, 1'b1, acc);
            else        cycle(1'b0, 0, 1'b0, 1'b1, 1'b1, acc);
            if (i > 0) begin
                chk("tbl_hs", int'(obs_hs), 1);
                chk("tbl_bit", int'(obs_bit), int'(tbl[i-1].b));
                chk("tbl_eol", int'(obs_eol), int'(tbl[i-1].eol));
                chk("tbl_eof", int'(obs_eof), int'(tbl[i-1].eof));
            end
        end
        // Rows 2.. with diffusion back on see only zero errors from row 1.
        for (int i = 16; i < NPIX; i++) cycle(1'b1, $urandom_range(255), 1'b0, 1'b1, 1'b1, acc);
        flush();

        do_reset();
        send_frame_const(0);
        chk("zero_ones", ones_cnt, 0);
        chk("zero_count", out_cnt, NPIX);
        chk("zero_eol", eol_cnt, ROWS);
        chk("zero_eof", eof_cnt, 1);
        chk("zero_eof_at", eof_at, NPIX);

        do_reset();
        send_frame_const(255);
        chk("white_ones", ones_cnt, NPIX);
        chk("white_eol", eol_cnt, ROWS);
        chk("white_eof_at", eof_at, NPIX);

        // Reference run without back-pressure, then the same pixels with a stall.
        for (int i = 0; i < NPIX; i++) pix_a[i] = $urandom_range(255);
        do_reset();
        for (int i = 0; i < NPIX; i++) cycle(1'b1, pix_a[i], i == 0, 1'b1, 1'b1, acc);
        flush();
        ref_log = obs_log;
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1'b1, pix_a[i], i == 0, 1'b1, 1'b1, acc);
        #1 snap = bus.out_bit;
        for (int s = 0; s < 5; s++) begin
            cycle(1'b1, pix_a[12], 1'b0, 1'b1, 1'b0, acc);
            chk("stall_in_ready", int'(bus.in_ready), 0);
            chk("stall_valid", int'(bus.out_valid), 1);
            chk("stall_bit", int'(bus.out_bit), int'(snap));
        end
        for (int i = 12; i < NPIX; i++) cycle(1'b1, pix_a[i], 1'b0, 1'b1, 1'b1, acc);
        flush();
        chk("stall_len", obs_log.size(), ref_log.size());
        for (int i = 0; i < NPIX; i++)
            if (i < obs_log.size() && i < ref_log.size())
                chk("stall_seq", int'(obs_log[i]), int'(ref_log[i]));

        // Start-of-frame at row 2 col 3 aborts the partial frame.
        do_reset();
        for (int i = 0; i < 2*COLS + 3; i++) cycle(1'b1, $urandom_range(255), i == 0, 1'b1, 1'b1, acc);
        cycle(1'b1, 200, 1'b1, 1'b1, 1'b1, acc);
        for (int i = 1; i < NPIX; i++) cycle(1'b1, $urandom_range(255), 1'b0, 1'b1, 1'b1, acc);
        flush();
        chk("sof_eof_cnt", eof_cnt, 1);
        chk("sof_eof_at", eof_at, 2*COLS + 3 + NPIX);

        // Reset in row 3 with a bit pending, then a fresh frame.
        do_reset();
        for (int i = 0; i < 3*COLS + 2; i++) cycle(1'b1, $urandom_range(255), i == 0, 1'b1, 1'b1, acc);
        do_reset();
        for (int i = 0; i < NPIX; i++) cycle(1'b1, $urandom_range(255), 1'b0, 1'b1, 1'b1, acc);
        flush();
        chk("rst_frame_eof", eof_at, NPIX);

        // Randomized traffic: gaps, back-pressure, diffusion toggling, stray sof.
        do_reset();
        for (int i = 0; i < 2500; i++)
            cycle($urandom_range(3) != 0, $urandom_range(255), $urandom_range(59) == 0,
                  $urandom_range(9) != 0, $urandom_range(9) < 7, acc);
        flush();
        chk("rand_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
